// File: rtl/mem_protocol_checker_if.sv
// Monitored single-port valid/ready memory bus.
// The master modport drives every signal; the checker observes through slave.
interface mem_protocol_checker_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 16
);
  logic                  wr_rd_i;
  logic                  valid_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [WIDTH-1:0]      wdata_i;
  logic [WIDTH-1:0]      rdata_o;
  logic                  ready_o;

  modport master (output wr_rd_i, valid_i, addr_i, wdata_i, rdata_o, ready_o);
  modport slave  (input  wr_rd_i, valid_i, addr_i, wdata_i, rdata_o, ready_o);
endinterface

// File: rtl/mem_protocol_checker.sv
// Passive protocol and read-data integrity checker for a valid/ready memory.
// Define MEM_PROTOCOL_CHECKER_SVA_EN to add one concurrent assertion per check.
`ifdef MEM_PROTOCOL_CHECKER_SVA_EN
module mem_protocol_checker_sva (
  input logic       clk_i,
  input logic       rst_i,
  input logic [7:0] ev_i
);
  a_stall:  assert property (@(posedge clk_i) disable iff (rst_i) !ev_i[0]) else $error("[%0t] STALL FAILED", $time);
  a_xctl:   assert property (@(posedge clk_i) disable iff (rst_i) !ev_i[1]) else $error("[%0t] XCTL FAILED", $time);
  a_addr:   assert property (@(posedge clk_i) disable iff (rst_i) !ev_i[2]) else $error("[%0t] ADDR FAILED", $time);
  a_xwdata: assert property (@(posedge clk_i) disable iff (rst_i) !ev_i[3]) else $error("[%0t] XWDATA FAILED", $time);
  a_xrdata: assert property (@(posedge clk_i) disable iff (rst_i) !ev_i[4]) else $error("[%0t] XRDATA FAILED", $time);
  a_data:   assert property (@(posedge clk_i) disable iff (rst_i) !ev_i[5]) else $error("[%0t] DATA FAILED", $time);
  a_uninit: assert property (@(posedge clk_i) disable iff (rst_i) !ev_i[6]) else $error("[%0t] UNINIT FAILED", $time);
  a_hold:   assert property (@(posedge clk_i) disable iff (rst_i) !ev_i[7]) else $error("[%0t] HOLD FAILED", $time);
endmodule
`endif

module mem_protocol_checker #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LATENCY = 1,
  parameter int MAX_STALL  = 0,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mem_protocol_checker_if.slave bus,
  output logic                  err_o,
  output logic [7:0]            err_code_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [CNT_WIDTH-1:0]  txn_cnt_o
);
  localparam int PL = (RD_LATENCY == 0) ? 1 : RD_LATENCY;
  localparam int SW = $clog2(MAX_STALL + 2);
  localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [SW-1:0]       STALL_LIM = SW'(MAX_STALL);
  localparam logic [SW-1:0]       STALL_SAT = SW'(MAX_STALL + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef struct packed {
    logic                  v;
    logic                  w;
    logic [WIDTH-1:0]      d;
    logic [ADDR_WIDTH-1:0] a;
  } slot_t;

  logic [WIDTH-1:0]      shadow_q [DEPTH];
  logic [DEPTH-1:0]      written_q, written_d;
  slot_t                 pipe_q [PL];
  slot_t                 pipe_d [PL];
  slot_t                 cap_s, due_s;
  logic [SW-1:0]         stall_cnt_q, stall_cnt_d;
  logic                  stall_q, wr_rd_q;
  logic [ADDR_WIDTH-1:0] addr_q, err_addr_q, err_addr_d;
  logic [WIDTH-1:0]      wdata_q;
  logic                  err_q, addr_cap_q, addr_cap_d;
  logic [7:0]            err_code_q, err_code_d, ev_s;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d, txn_cnt_q, txn_cnt_d;
  logic hs_s, ctl_x_s, addr_bad_s, wdata_x_s, is_wr_s, is_rd_s, stall_s, shadow_we_s;

  // Request decode and read-slot capture from the shadow at the handshake.
  always_comb begin
    hs_s        = bus.valid_i && bus.ready_o;
    ctl_x_s     = $isunknown(bus.wr_rd_i);
    addr_bad_s  = $isunknown(bus.addr_i) || ({1'b0, bus.addr_i} >= DEPTH_C);
    wdata_x_s   = $isunknown(bus.wdata_i);
    is_wr_s     = !ctl_x_s && bus.wr_rd_i;
    is_rd_s     = !ctl_x_s && !bus.wr_rd_i;
    stall_s     = bus.valid_i && !bus.ready_o;
    shadow_we_s = hs_s && is_wr_s && !addr_bad_s && !wdata_x_s;
    cap_s.v     = hs_s && is_rd_s && !addr_bad_s;
    cap_s.w     = cap_s.v && written_q[bus.addr_i];
    cap_s.d     = shadow_q[bus.addr_i];
    cap_s.a     = bus.addr_i;
  end

  if (RD_LATENCY == 0) begin : g_lat0
    assign due_s = cap_s;
  end else begin : g_latn
    assign due_s = pipe_q[PL-1];
  end

  // Check events and next-state for flags, counters, bitmap and pipeline.
  always_comb begin
    ev_s        = 8'h00;
    ev_s[0]     = stall_s && (stall_cnt_q == STALL_LIM);
    ev_s[1]     = hs_s && ctl_x_s;
    ev_s[2]     = hs_s && addr_bad_s;
    ev_s[3]     = hs_s && is_wr_s && wdata_x_s;
    ev_s[4]     = due_s.v && $isunknown(bus.rdata_o);
    ev_s[5]     = due_s.v && due_s.w && ($isunknown(bus.rdata_o) || (bus.rdata_o != due_s.d));
    ev_s[6]     = cap_s.v && !cap_s.w;
    ev_s[7]     = stall_q && (!bus.valid_i || (bus.wr_rd_i != wr_rd_q) ||
                              (bus.addr_i != addr_q) || (bus.wdata_i != wdata_q));
    err_code_d  = err_code_q | ev_s;
    err_cnt_d   = err_cnt_q;
    err_addr_d  = err_addr_q;
    addr_cap_d  = addr_cap_q;
    txn_cnt_d   = txn_cnt_q;
    written_d   = written_q;
    stall_cnt_d = {SW{1'b0}};
    pipe_d[0]   = cap_s;
    for (int i = 1; i < PL; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    if (|ev_s) begin
      if (err_cnt_q != CNT_MAX) begin
        err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      end else begin
        err_cnt_d = err_cnt_q;
      end
      // A due-data error names the slot address even if the handshake also failed.
      if (!addr_cap_q) begin
        addr_cap_d = 1'b1;
        err_addr_d = (ev_s[4] || ev_s[5]) ? due_s.a : bus.addr_i;
      end else begin
        addr_cap_d = 1'b1;
      end
    end else begin
      err_cnt_d = err_cnt_q;
    end
    if (hs_s) begin
      txn_cnt_d = txn_cnt_q + CNT_WIDTH'(1);
    end else begin
      txn_cnt_d = txn_cnt_q;
    end
    if (shadow_we_s) begin
      written_d[bus.addr_i] = 1'b1;
    end else begin
      written_d = written_q;
    end
    if (stall_s) begin
      stall_cnt_d = (stall_cnt_q == STALL_SAT) ? stall_cnt_q : stall_cnt_q + SW'(1);
    end else begin
      stall_cnt_d = {SW{1'b0}};
    end
  end

  // Shadow data words; deliberately not reset, the written bitmap guards them.
  always_ff @(posedge clk_i) begin
    if (shadow_we_s) shadow_q[bus.addr_i] <= bus.wdata_i;
  end

  // Checker state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      written_q   <= {DEPTH{1'b0}};
      stall_cnt_q <= {SW{1'b0}};
      stall_q     <= 1'b0;
      wr_rd_q     <= 1'b0;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      wdata_q     <= {WIDTH{1'b0}};
      err_q       <= 1'b0;
      err_code_q  <= 8'h00;
      err_cnt_q   <= {CNT_WIDTH{1'b0}};
      err_addr_q  <= {ADDR_WIDTH{1'b0}};
      addr_cap_q  <= 1'b0;
      txn_cnt_q   <= {CNT_WIDTH{1'b0}};
      for (int i = 0; i < PL; i++) pipe_q[i] <= '0;
    end else begin
      written_q   <= written_d;
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_s;
      wr_rd_q     <= bus.wr_rd_i;
      addr_q      <= bus.addr_i;
      wdata_q     <= bus.wdata_i;
      err_q       <= |err_code_d;
      err_code_q  <= err_code_d;
      err_cnt_q   <= err_cnt_d;
      err_addr_q  <= err_addr_d;
      addr_cap_q  <= addr_cap_d;
      txn_cnt_q   <= txn_cnt_d;
      for (int i = 0; i < PL; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign err_cnt_o  = err_cnt_q;
  assign err_addr_o = err_addr_q;
  assign txn_cnt_o  = txn_cnt_q;

`ifdef MEM_PROTOCOL_CHECKER_SVA_EN
  mem_protocol_checker_sva u_sva (.clk_i(clk_i), .rst_i(rst_i), .ev_i(ev_s));
`else
  // Flags and counters only in this build.
`endif
endmodule

// File: tb/tb_mem_protocol_checker.sv
// Self-checking bench: directed vector table, hand sequences and a random run
// compared against a queue-based reference model of the checking rules.
module tb_mem_protocol_checker;
  localparam int DEPTH = 16;
  localparam int LAT   = 1;
  localparam int MAXS  = 0;
  localparam int CMAX  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_protocol_checker_if #(.ADDR_WIDTH(4), .WIDTH(16)) bus ();
  mem_protocol_checker_if #(.ADDR_WIDTH(4), .WIDTH(16)) bus2 ();

  logic err, err2;
  logic [7:0] code, code2, cnt, cnt2, txn, txn2;
  logic [3:0] eaddr, eaddr2;

  mem_protocol_checker u_dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave), .err_o(err), .err_code_o(code),
    .err_cnt_o(cnt), .err_addr_o(eaddr), .txn_cnt_o(txn));

  mem_protocol_checker #(.MAX_STALL(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .bus(bus2.slave), .err_o(err2), .err_code_o(code2),
    .err_cnt_o(cnt2), .err_addr_o(eaddr2), .txn_cnt_o(txn2));

  int n_chk = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  typedef struct {int due; bit w; logic [15:0] d; logic [3:0] a;} pend_t;
  logic [15:0] m_mem [DEPTH];
  bit          m_wr [DEPTH];
  pend_t       m_q [$];
  int          m_cyc = 0, m_stall, m_cnt, m_txn;
  bit          m_prev_stall, m_cap;
  logic        m_pwr;
  logic [3:0]  m_paddr, m_eaddr;
  logic [15:0] m_pwdata;
  logic [7:0]  m_code;

  task automatic m_reset();
    m_q.delete();
    foreach (m_wr[i]) m_wr[i] = 1'b0;
    m_stall = 0; m_prev_stall = 1'b0; m_cap = 1'b0;
    m_code = 8'h00; m_cnt = 0; m_txn = 0; m_eaddr = 4'd0;
  endtask

  task automatic m_step();
    logic [7:0] ev;
    bit hs, cx, ab, wx, wr, rd;
    logic [3:0] due_a;
    pend_t p;
    ev = 8'h00;
    due_a = bus.addr_i;
    hs = (bus.valid_i === 1'b1) && (bus.ready_o === 1'b1);
    cx = $isunknown(bus.wr_rd_i);
    ab = $isunknown(bus.addr_i) || (int'(bus.addr_i) >= DEPTH);
    wx = $isunknown(bus.wdata_i);
    wr = hs && !cx && (bus.wr_rd_i === 1'b1);
    rd = hs && !cx && (bus.wr_rd_i === 1'b0);
    if (bus.valid_i && !bus.ready_o) begin
      m_stall++;
      if (m_stall == MAXS + 1) ev[0] = 1'b1;
    end else begin
      m_stall = 0;
    end
    if (m_prev_stall && (!bus.valid_i || bus.wr_rd_i !== m_pwr ||
        bus.addr_i !== m_paddr || bus.wdata_i !== m_pwdata)) ev[7] = 1'b1;
    m_prev_stall = bus.valid_i && !bus.ready_o;
    m_pwr = bus.wr_rd_i; m_paddr = bus.addr_i; m_pwdata = bus.wdata_i;
    if (hs && cx) ev[1] = 1'b1;
    if (hs && ab) ev[2] = 1'b1;
    if (wr && wx) ev[3] = 1'b1;
    if (rd && !ab) begin
      if (!m_wr[bus.addr_i]) ev[6] = 1'b1;
      p.due = m_cyc + LAT; p.w = m_wr[bus.addr_i];
      p.d = m_mem[bus.addr_i]; p.a = bus.addr_i;
      m_q.push_back(p);
    end
    if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
      p = m_q.pop_front();
      due_a = p.a;
      if ($isunknown(bus.rdata_o)) ev[4] = 1'b1;
      if (p.w && (bus.rdata_o !== p.d)) ev[5] = 1'b1;
    end
    if (ev != 8'h00) begin
      if (m_cnt < CMAX) m_cnt++;
      if (!m_cap) begin
        m_cap = 1'b1;
        m_eaddr = (ev[4] || ev[5]) ? due_a : bus.addr_i;
      end
    end
    m_code = m_code | ev;
    if (hs) m_txn = (m_txn + 1) % 256;
    if (wr && !ab && !wx) begin
      m_mem[bus.addr_i] = bus.wdata_i;
      m_wr[bus.addr_i] = 1'b1;
    end
    m_cyc++;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("err_o",      32'(err),   32'(m_code != 8'h00));
    chk("err_code_o", 32'(code),  32'(m_code));
    chk("err_cnt_o",  32'(cnt),   m_cnt);
    chk("err_addr_o", 32'(eaddr), 32'(m_eaddr));
    chk("txn_cnt_o",  32'(txn),   m_txn);
  endtask

  task automatic drive(input logic v, input logic r, input logic w, input logic [3:0] a,
                       input logic [15:0] wd, input logic [15:0] rd);
    bus.valid_i = v; bus.ready_o = r; bus.wr_rd_i = w;
    bus.addr_i = a; bus.wdata_i = wd; bus.rdata_o = rd;
  endtask

  task automatic drive2(input logic v, input logic r, input logic w, input logic [3:0] a);
    bus2.valid_i = v; bus2.ready_o = r; bus2.wr_rd_i = w;
    bus2.addr_i = a; bus2.wdata_i = 16'h1111; bus2.rdata_o = 16'h0000;
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_reset();
    cmp_model();
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    bit rst; logic v; logic r; logic w; logic [3:0] a; logic [15:0] wd; logic [15:0] rd;
    logic [7:0] code; int cnt; int txn; logic [3:0] ea;
  } vec_t;
  vec_t tbl [10];

  initial begin
    logic xs_ctl, xs_wd;
    drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000);
    drive2(1'b0, 1'b1, 1'b0, 4'd0);

    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 16'hA5A5, 16'h0000, 8'h00, 32'd0, 32'd1, 4'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 16'h0000, 16'h0000, 8'h00, 32'd0, 32'd2, 4'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'hA5A5, 8'h00, 32'd0, 32'd2, 4'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 16'h0000, 16'h0000, 8'h00, 32'd0, 32'd3, 4'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'hA5A4, 8'h20, 32'd1, 32'd3, 4'd3};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000, 8'h00, 32'd0, 32'd0, 4'd0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 16'h0000, 16'h0000, 8'h40, 32'd1, 32'd1, 4'd7};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'($urandom), 8'h40, 32'd1, 32'd1, 4'd7};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 16'h0000, 16'h0000, 8'h40, 32'd2, 32'd2, 4'd7};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'hA5A5, 8'h40, 32'd2, 32'd2, 4'd7};

    do_reset();
    chk("reset_err_o", 32'(err), 32'd0);
    chk("reset_txn", 32'(txn), 32'd0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        drive(tbl[i].v, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].rd);
        tick();
      end
      chk("tbl_err_o", 32'(err), 32'(tbl[i].code != 8'h00));
      chk("tbl_code", 32'(code), 32'(tbl[i].code));
      chk("tbl_cnt", 32'(cnt), tbl[i].cnt);
      chk("tbl_txn", 32'(txn), tbl[i].txn);
      chk("tbl_addr", 32'(eaddr), 32'(tbl[i].ea));
    end

    // Stall tolerance 2 on the second instance, address changed mid-stall.
    do_reset();
    drive2(1'b1, 1'b0, 1'b1, 4'd5);
    tick();
    chk("stall_tolerated", 32'(code2), 32'h00);
    drive2(1'b1, 1'b0, 1'b1, 4'd6);
    tick();
    chk("hold_flag", 32'(code2), 32'h80);
    tick();
    chk("stall_flag", 32'(code2), 32'h81);
    drive2(1'b1, 1'b1, 1'b1, 4'd6);
    tick();
    drive2(1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    chk("stall_code", 32'(code2), 32'h81);
    chk("stall_cnt", 32'(cnt2), 32'd2);
    chk("stall_addr", 32'(eaddr2), 32'd6);
    chk("stall_err_o", 32'(err2), 32'd1);
    chk("stall_txn", 32'(txn2), 32'd1);

    // Unknown control and unknown write data; expectation follows how the
    // simulator actually represents the driven values.
    do_reset();
    drive(1'b1, 1'b1, 1'bx, 4'd9, 16'h1234, 16'h0000);
    xs_ctl = $isunknown(bus.wr_rd_i);
    tick();
    drive(1'b1, 1'b1, 1'b1, 4'd10, 16'hxxxx, 16'h0000);
    xs_wd = $isunknown(bus.wdata_i);
    tick();
    chk("xctl_flag", 32'(code[1]), 32'(xs_ctl));
    chk("xwdata_flag", 32'(code[3]), 32'(xs_wd));
    drive(1'b1, 1'b1, 1'b0, 4'd10, 16'h0000, 16'h0000);
    tick();
    if (xs_wd) chk("xwdata_no_shadow", 32'(code[6]), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 4'd9, 16'h0000, 16'h0000);
    tick();
    drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000);
    tick();

    // Counter saturation, then reset with a read in flight.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000);
      tick();
    end
    chk("cnt_saturated", 32'(cnt), 32'd255);
    drive(1'b1, 1'b1, 1'b1, 4'd2, 16'hBEEF, 16'h0000);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'd2, 16'h0000, 16'h0000);
    tick();
    drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000);
    rst = 1'b1;
    #1;
    chk("async_rst_err_o", 32'(err), 32'd0);
    chk("async_rst_code", 32'(code), 32'd0);
    chk("async_rst_cnt", 32'(cnt), 32'd0);
    chk("async_rst_addr", 32'(eaddr), 32'd0);
    chk("async_rst_txn", 32'(txn), 32'd0);
    m_reset();
    @(posedge clk);
    m_cyc++;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("no_data_after_rst", 32'(code), 32'd0);

    // Randomized bursts against the model.
    for (int b = 0; b < 10; b++) begin
      do_reset();
      for (int c = 0; c < 40; c++) begin
        if (!(m_prev_stall && $urandom_range(0, 9) != 0)) begin
          bus.valid_i = ($urandom_range(0, 3) != 0);
          bus.wr_rd_i = 1'($urandom_range(0, 1));
          bus.addr_i  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
          bus.wdata_i = 16'($urandom);
        end
        bus.ready_o = ($urandom_range(0, 5) != 0);
        if (m_q.size() > 0 && m_q[0].due == m_cyc && m_q[0].w && $urandom_range(0, 7) != 0)
          bus.rdata_o = m_q[0].d;
        else
          bus.rdata_o = 16'($urandom);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
